pll_reset_sequencer: RTL

- Sits directly downstream of the iCE40 PLL wrapper and runs in the 48 MHz PLL output domain.
- Synchronises the PLL lock indication and requires it to stay stable for a programmable interval before releasing the system reset.
- Re-asserts reset on lock loss or on a software request, and keeps lock-loss statistics for debug.

---
 rtl/pll_reset_sequencer_pkg.sv | 23 ++
 rtl/pll_reset_sequencer_sync_bit.sv | 27 ++
 rtl/pll_reset_sequencer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/pll_reset_sequencer_pkg.sv
// pll_reset_sequencer_pkg: shared state encoding and counter sizing (rev 1.0)
`default_nettype none

package pll_reset_sequencer_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    RUN       = 2'd2,
    SOFT_RST  = 2'd3
  } state_t;

  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pll_reset_sequencer_sync_bit.sv
// sync_bit: SYNC_STAGES-deep single-bit synchroniser, async reset to 0 (rev 1.0)
`default_nettype none

module sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] r_chain;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = r_chain[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: holds sys_reset until PLL lock is stable, with lock-loss stats (rev 1.0)
`default_nettype none

module pll_reset_sequencer
  import pll_reset_sequencer_pkg::*;
#(
  parameter int SYNC_STAGES       = 2,
  parameter int STABLE_CYCLES     = 4096,
  parameter int SOFT_RESET_CYCLES = 16,
  parameter int COUNT_WIDTH       = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   pll_locked,
  input  logic                   soft_reset_req,
  input  logic                   clear_status,
  output logic                   sys_reset,
  output logic                   lock_lost,
  output logic [COUNT_WIDTH-1:0] lock_loss_count,
  output logic [STATE_W-1:0]     state
);

  localparam int               CNT_W       = cnt_width(STABLE_CYCLES, SOFT_RESET_CYCLES);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SOFT_LAST   = CNT_W'(SOFT_RESET_CYCLES - 1);

  logic                   w_locked_s;
  state_t                 r_state;
  state_t                 w_state_next;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_next;
  logic                   w_loss_event;
  logic [COUNT_WIDTH-1:0] w_count_base;
  logic                   r_sys_reset;
  logic                   r_lock_lost;
  logic [COUNT_WIDTH-1:0] r_loss_count;

  sync_bit #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clock(clock),
    .reset(reset),
    .d    (pll_locked),
    .q    (w_locked_s)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= WAIT_LOCK;
      r_cnt       <= '0;
      r_sys_reset <= 1'b1;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_sys_reset <= (w_state_next != RUN);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_loss_event = 1'b0;
    case (r_state)
      WAIT_LOCK: begin
        if (w_locked_s) begin
          w_state_next = STABILIZE;
          w_cnt_next   = '0;
        end
      end
      STABILIZE: begin
        if (!w_locked_s) begin
          w_state_next = WAIT_LOCK;
        end else if (r_cnt == STABLE_LAST) begin
          w_state_next = RUN;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      RUN: begin
        // Lock loss takes priority over a coincident software request.
        if (!w_locked_s) begin
          w_state_next = WAIT_LOCK;
          w_loss_event = 1'b1;
        end else if (soft_reset_req) begin
          w_state_next = SOFT_RST;
          w_cnt_next   = '0;
        end
      end
      SOFT_RST: begin
        if (!w_locked_s) begin
          w_state_next = WAIT_LOCK;
          w_loss_event = 1'b1;
        end else if (r_cnt == SOFT_LAST) begin
          w_state_next = RUN;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_next = WAIT_LOCK;
      end
    endcase
  end

  // A clear coinciding with an event counts the event from zero.
  assign w_count_base = clear_status ? '0 : r_loss_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_lock_lost  <= 1'b0;
      r_loss_count <= '0;
    end else begin
      r_lock_lost <= w_loss_event | (r_lock_lost & ~clear_status);
      if (w_loss_event) begin
        r_loss_count <= (&w_count_base) ? w_count_base : w_count_base + COUNT_WIDTH'(1);
      end else if (clear_status) begin
        r_loss_count <= '0;
      end
    end
  end

  assign sys_reset       = r_sys_reset;
  assign lock_lost       = r_lock_lost;
  assign lock_loss_count = r_loss_count;
  assign state           = r_state;

endmodule

`default_nettype wire
